weight_buffer_ctrl: RTL

WEIGHT_BUFFER_CTRL -- requirements
Module: weight_buffer_ctrl

---
 rtl/weight_buffer_ctrl_if.sv | 44 ++++
 rtl/weight_buffer_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// weight_buffer_ctrl_if
//
// Groups the loader write handshake, the dispatcher read handshake and the
// read-response strobe of the weight buffer controller.
//
//   ld_valid / ld_ready   loader write request / grant
//   ld_addr  / ld_data    row to write and its contents
//   rd_valid / rd_ready   dispatcher read request / grant
//   rd_addr               row to read
//   rsp_valid             buffer rdata holds the oldest granted read
//
// master: the requesting side (loader + dispatcher).
// slave : the controller.
// -----------------------------------------------------------------------------
interface weight_buffer_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4096
);

  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  rsp_valid;

  modport master (
    output ld_valid, ld_addr, ld_data,
    output rd_valid, rd_addr,
    input  ld_ready, rd_ready, rsp_valid
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    input  rd_valid, rd_addr,
    output ld_ready, rd_ready, rsp_valid
  );

endinterface

// File: rtl/weight_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// weight_buffer_ctrl
//
// Arbitrates a single shared weight-buffer port between a loader (writes) and
// a dispatcher (reads). A per-row valid scoreboard holds reads back until the
// row has been written; writes normally win, but after MAX_WR_BURST writes
// granted while a read is waiting, the read is let through once.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   clr              pulse: invalidates every row at the next edge
//   bus (slave)      loader/dispatcher handshakes and rsp_valid
//   out_dram_req/we  buffer write port strobe (one cycle per write grant)
//   out_dram_addr    buffer write row  (0 when no write is issued)
//   out_dram_wdata   buffer write data (0 when no write is issued)
//   out_disp_req     buffer read port strobe (one cycle per read grant)
//   out_disp_addr    buffer read row (holds the last issued row)
//   row_valid_cnt    number of rows currently marked valid (0..2**ADDR_WIDTH)
//
// RD_LAT must be at least 1.
// -----------------------------------------------------------------------------
module weight_buffer_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 4096,
  parameter int RD_LAT       = 3,
  parameter int MAX_WR_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  weight_buffer_ctrl_if.slave   bus,
  output logic                  out_dram_req,
  output logic                  out_dram_we,
  output logic [ADDR_WIDTH-1:0] out_dram_addr,
  output logic [DATA_WIDTH-1:0] out_dram_wdata,
  output logic                  out_disp_req,
  output logic [ADDR_WIDTH-1:0] out_disp_addr,
  output logic [ADDR_WIDTH:0]   row_valid_cnt
);

  localparam int NUM_ROWS = 1 << ADDR_WIDTH;
  localparam int CNT_W    = $clog2(MAX_WR_BURST + 1);
  localparam logic [CNT_W-1:0] WR_BURST_MAX = CNT_W'(MAX_WR_BURST);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  active_q;          // low until first edge after reset
  logic [NUM_ROWS-1:0]   row_valid_q, row_valid_d;
  logic [ADDR_WIDTH:0]   row_valid_cnt_q, row_valid_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

  logic                  dram_req_q;
  logic [ADDR_WIDTH-1:0] dram_addr_q;
  logic [DATA_WIDTH-1:0] dram_wdata_q;
  logic                  disp_req_q;
  logic [ADDR_WIDTH-1:0] disp_addr_q;
  logic [RD_LAT:0]       rsp_sr_q;          // read-grant age, one bit per clock

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic rd_eligible;
  logic burst_limit;
  logic grant_en;
  logic ld_grant;
  logic rd_grant;

  assign rd_eligible = bus.rd_valid & row_valid_q[bus.rd_addr];

  // A waiting eligible read takes the port once the write burst has used up
  // its allowance; otherwise any pending write takes it.
  assign burst_limit = rd_eligible & (wr_cnt_q == WR_BURST_MAX);
  assign grant_en    = active_q & ~clr;
  assign ld_grant    = grant_en & bus.ld_valid & ~burst_limit;
  assign rd_grant    = grant_en & rd_eligible & ~ld_grant;

  assign bus.ld_ready = ld_grant;
  assign bus.rd_ready = rd_grant;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb block gets its default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (clr || rd_grant || !rd_eligible) begin
      wr_cnt_d = '0;
    end else if (ld_grant && (wr_cnt_q != WR_BURST_MAX)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  // Only a write to a row that was not yet valid grows the count, so the
  // count tops out at NUM_ROWS and never wraps.
  always_comb begin
    row_valid_d     = row_valid_q;
    row_valid_cnt_d = row_valid_cnt_q;
    if (clr) begin
      row_valid_d     = '0;
      row_valid_cnt_d = '0;
    end else if (ld_grant && !row_valid_q[bus.ld_addr]) begin
      row_valid_d[bus.ld_addr] = 1'b1;
      row_valid_cnt_d          = row_valid_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  // NOTE: the row scoreboard is a flop vector, not a RAM, so it is reset along
  // with the rest of the state; a stale valid bit after reset would let a read
  // through to an unwritten row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q        <= 1'b0;
      row_valid_q     <= '0;
      row_valid_cnt_q <= '0;
      wr_cnt_q        <= '0;
    end else begin
      active_q        <= 1'b1;
      row_valid_q     <= row_valid_d;
      row_valid_cnt_q <= row_valid_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
    end
  end

  // Write port: address and data are forced to zero outside a write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_req_q   <= 1'b0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
    end else begin
      dram_req_q   <= ld_grant;
      dram_addr_q  <= ld_grant ? bus.ld_addr : '0;
      dram_wdata_q <= ld_grant ? bus.ld_data : '0;
    end
  end

  // Read port: the address holds its last value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_req_q  <= 1'b0;
      disp_addr_q <= '0;
    end else begin
      disp_req_q <= rd_grant;
      if (rd_grant) begin
        disp_addr_q <= bus.rd_addr;
      end
    end
  end

  // The buffer samples out_disp_req one edge after the grant and has rdata
  // RD_LAT edges later, so the delay line is fed from the registered strobe.
  // clr deliberately leaves it alone: reads already issued still complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sr_q <= '0;
    end else begin
      rsp_sr_q <= {rsp_sr_q[RD_LAT-1:0], disp_req_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_dram_req   = dram_req_q;
  assign out_dram_we    = dram_req_q;
  assign out_dram_addr  = dram_addr_q;
  assign out_dram_wdata = dram_wdata_q;
  assign out_disp_req   = disp_req_q;
  assign out_disp_addr  = disp_addr_q;
  assign row_valid_cnt  = row_valid_cnt_q;
  assign bus.rsp_valid  = rsp_sr_q[RD_LAT];

endmodule
